// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR user port among NUM_REQ requesters.
// One transfer in flight at a time; every output is registered.
module ddr_port_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 27,
    parameter  int DATA_WIDTH = 256,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_wr,
    input  logic [NUM_REQ-1:0]            i_req_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
    input  logic [NUM_REQ*BE_WIDTH-1:0]   i_req_be_n,
    output logic [NUM_REQ-1:0]            o_req_done,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_ddr_wr_data_valid,
    output logic [DATA_WIDTH-1:0]         o_ddr_wr_data,
    output logic [BE_WIDTH-1:0]           o_ddr_wr_data_be_n,
    output logic [ADDR_WIDTH-1:0]         o_ddr_addr,
    output logic                          o_ddr_rd,
    input  logic                          i_ddr_wr_ack,
    input  logic                          i_ddr_rd_ack,
    input  logic [DATA_WIDTH-1:0]         i_ddr_rd_data,
    input  logic                          i_ddr_rd_data_valid,
    output logic                          o_busy,
    output logic [ID_WIDTH-1:0]           o_grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RD_DATA,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   gid_q, gid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0]    req_any;
    logic                  found;
    logic [ID_WIDTH-1:0]   owner;
    logic                  owner_wr;
    int                    scan_idx;

    assign req_any  = i_req_wr | i_req_rd;
    assign owner_wr = i_req_wr[owner];

    // First active requester at or above the pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        owner    = ptr_q;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_any[scan_idx]) begin
                found = 1'b1;
                owner = ID_WIDTH'(scan_idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = owner_wr ? WR_WAIT : RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (i_ddr_wr_ack) begin
                    state_d = DONE;
                end
            end
            RD_WAIT: begin
                if (i_ddr_rd_ack) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (i_ddr_rd_data_valid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        wr_valid_d = wr_valid_q;
        rd_d       = rd_q;
        done_d     = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        busy_d     = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_d      = (owner == ID_WIDTH'(NUM_REQ - 1))
                               ? '0 : owner + 1'b1;
                    gid_d      = owner;
                    addr_d     = i_req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = i_req_wr_data[owner*DATA_WIDTH +: DATA_WIDTH];
                    be_d       = i_req_be_n[owner*BE_WIDTH +: BE_WIDTH];
                    wr_valid_d = owner_wr;
                    rd_d       = !owner_wr;
                end
            end
            WR_WAIT: begin
                if (i_ddr_wr_ack) begin
                    wr_valid_d     = 1'b0;
                    done_d[gid_q]  = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_ddr_rd_ack) begin
                    rd_d = 1'b0;
                end
            end
            RD_DATA: begin
                if (i_ddr_rd_data_valid) begin
                    rdata_d        = i_ddr_rd_data;
                    done_d[gid_q]  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            gid_q      <= '0;
            wr_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            wr_valid_q <= wr_valid_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_req_done          = done_q;
    assign o_rd_data           = rdata_q;
    assign o_ddr_wr_data_valid = wr_valid_q;
    assign o_ddr_wr_data       = wdata_q;
    assign o_ddr_wr_data_be_n  = be_q;
    assign o_ddr_addr          = addr_q;
    assign o_ddr_rd            = rd_q;
    assign o_busy              = busy_q;
    assign o_grant_id          = gid_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: write, read, fairness,
// wr/rd ordering, reset mid-read and spurious DDR handshakes.
module tb_ddr_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 27;
    localparam int DW = 256;
    localparam int BW = DW / 8;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  req_wr;
    logic [NR-1:0]  req_rd;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*BW-1:0] req_be_n;
    logic [NR-1:0]  req_done;
    logic [DW-1:0]  rd_data;
    logic           ddr_wr_valid;
    logic [DW-1:0]  ddr_wr_data;
    logic [BW-1:0]  ddr_be_n;
    logic [AW-1:0]  ddr_addr;
    logic           ddr_rd;
    logic           ddr_wr_ack;
    logic           wr_ack_man;
    logic           wr_ack_auto;
    logic           auto_en;
    logic           ddr_rd_ack;
    logic [DW-1:0]  ddr_rd_data;
    logic           ddr_rd_valid;
    logic           busy;
    logic [1:0]     grant_id;

    int n_cmp;
    int n_err;

    assign ddr_wr_ack = wr_ack_man | wr_ack_auto;

    ddr_port_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req_wr           (req_wr),
        .i_req_rd           (req_rd),
        .i_req_addr         (req_addr),
        .i_req_wr_data      (req_wdata),
        .i_req_be_n         (req_be_n),
        .o_req_done         (req_done),
        .o_rd_data          (rd_data),
        .o_ddr_wr_data_valid(ddr_wr_valid),
        .o_ddr_wr_data      (ddr_wr_data),
        .o_ddr_wr_data_be_n (ddr_be_n),
        .o_ddr_addr         (ddr_addr),
        .o_ddr_rd           (ddr_rd),
        .i_ddr_wr_ack       (ddr_wr_ack),
        .i_ddr_rd_ack       (ddr_rd_ack),
        .i_ddr_rd_data      (ddr_rd_data),
        .i_ddr_rd_data_valid(ddr_rd_valid),
        .o_busy             (busy),
        .o_grant_id         (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DDR model acks a write the cycle after it first sees the command.
    always @(posedge clk) begin
        wr_ack_auto <= auto_en & ddr_wr_valid & ~wr_ack_auto;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [DW-1:0] wpat;
    logic [DW-1:0] rpat;
    int            gid_seen [8];
    int            cyc_seen [8];
    int            n_g;
    logic          prev_v;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; req_wr = '0; req_rd = '0;
        req_addr = '0; req_wdata = '0; req_be_n = '1;
        wr_ack_man = 1'b0; wr_ack_auto = 1'b0; auto_en = 1'b0;
        ddr_rd_ack = 1'b0; ddr_rd_data = '0; ddr_rd_valid = 1'b0;
        wpat = {8{32'hDEADBEEF}};
        rpat = {32{8'hA5}};

        tick();
        tick();
        chk("rst_busy", DW'(busy), '0);
        chk("rst_gid", DW'(grant_id), '0);
        chk("rst_wrv", DW'(ddr_wr_valid), '0);
        chk("rst_rd", DW'(ddr_rd), '0);
        chk("rst_done", DW'(req_done), '0);
        chk("rst_addr", DW'(ddr_addr), '0);
        chk("rst_be", DW'(ddr_be_n), '0);

        rst_n = 1'b1;
        wr_ack_man = 1'b1; ddr_rd_valid = 1'b1;
        tick();
        chk("spur_idle_busy", DW'(busy), '0);
        chk("spur_idle_done", DW'(req_done), '0);
        wr_ack_man = 1'b0; ddr_rd_valid = 1'b0;

        // single write from requester 2
        req_wr[2] = 1'b1;
        req_addr[2*AW +: AW] = 27'h0001234;
        req_wdata[2*DW +: DW] = wpat;
        req_be_n[2*BW +: BW] = '0;
        tick();
        chk("wr_valid0", DW'(ddr_wr_valid), 1);
        chk("wr_addr", DW'(ddr_addr), 256'h1234);
        chk("wr_gid", DW'(grant_id), 2);
        chk("wr_busy", DW'(busy), 1);
        req_wr = '0;
        req_addr[2*AW +: AW] = 27'h7FFFFFF;
        req_wdata[2*DW +: DW] = '0;
        req_be_n[2*BW +: BW] = '1;
        ddr_rd_valid = 1'b1;
        tick();
        chk("wr_valid1", DW'(ddr_wr_valid), 1);
        chk("spur_wr_done", DW'(req_done), '0);
        chk("wr_addr_hold", DW'(ddr_addr), 256'h1234);
        chk("wr_data_hold", ddr_wr_data, wpat);
        chk("wr_be_hold", DW'(ddr_be_n), '0);
        ddr_rd_valid = 1'b0;
        tick();
        chk("wr_valid2", DW'(ddr_wr_valid), 1);
        wr_ack_man = 1'b1;
        tick();
        chk("wr_valid_clr", DW'(ddr_wr_valid), 0);
        chk("wr_done", DW'(req_done), 256'b0100);
        wr_ack_man = 1'b0;
        tick();
        chk("wr_done_end", DW'(req_done), '0);
        chk("wr_idle", DW'(busy), 0);

        // read from requester 1
        req_rd[1] = 1'b1;
        req_addr[1*AW +: AW] = 27'h0ABCDEF;
        tick();
        chk("rd_cmd", DW'(ddr_rd), 1);
        chk("rd_gid", DW'(grant_id), 1);
        chk("rd_addr", DW'(ddr_addr), 256'hABCDEF);
        tick();
        chk("rd_cmd_hold", DW'(ddr_rd), 1);
        ddr_rd_ack = 1'b1;
        tick();
        chk("rd_cmd_clr", DW'(ddr_rd), 0);
        ddr_rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_wait_done", DW'(req_done), '0);
        end
        ddr_rd_valid = 1'b1; ddr_rd_data = rpat;
        tick();
        chk("rd_done", DW'(req_done), 256'b0010);
        chk("rd_data", rd_data, rpat);
        req_rd = '0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;
        tick();
        chk("rd_done_end", DW'(req_done), '0);

        // fairness: reset so arbitration restarts at requester 0
        rst_n = 1'b0;
        tick();
        req_wr = '1; auto_en = 1'b1; rst_n = 1'b1;
        n_g = 0; prev_v = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (ddr_wr_valid && !prev_v) begin
                if (n_g < 8) begin
                    gid_seen[n_g] = int'(grant_id);
                    cyc_seen[n_g] = c;
                end
                n_g++;
            end
            prev_v = ddr_wr_valid;
        end
        req_wr = '0; auto_en = 1'b0;
        chk("rr_count", DW'(n_g), 6);
        for (int g = 0; g < 6 && g < n_g; g++) begin
            chk("rr_gid", DW'(gid_seen[g]), DW'(g % 4));
            chk("rr_cycle", DW'(cyc_seen[g]), DW'(g * 4));
        end
        tick();
        chk("rr_idle", DW'(busy), 0);

        // requester 3 with write and read both pending
        req_wr[3] = 1'b1; req_rd[3] = 1'b1;
        req_addr[3*AW +: AW] = 27'h0000333;
        tick();
        chk("wr1st_valid", DW'(ddr_wr_valid), 1);
        chk("wr1st_rd", DW'(ddr_rd), 0);
        chk("wr1st_gid", DW'(grant_id), 3);
        wr_ack_man = 1'b1;
        tick();
        chk("wr1st_done", DW'(req_done), 256'b1000);
        wr_ack_man = 1'b0; req_wr[3] = 1'b0;
        tick();
        chk("wr1st_gap", DW'(busy), 0);
        tick();
        chk("rd2nd_cmd", DW'(ddr_rd), 1);
        chk("rd2nd_wrv", DW'(ddr_wr_valid), 0);
        chk("rd2nd_gid", DW'(grant_id), 3);
        ddr_rd_ack = 1'b1;
        tick();
        chk("rd2nd_acked", DW'(ddr_rd), 0);
        ddr_rd_ack = 1'b0;

        // asynchronous reset while waiting for read data
        rst_n = 1'b0;
        #1;
        chk("arst_busy", DW'(busy), 0);
        chk("arst_gid", DW'(grant_id), 0);
        chk("arst_addr", DW'(ddr_addr), 0);
        chk("arst_done", DW'(req_done), 0);
        @(negedge clk);
        rst_n = 1'b1; req_rd = '0;
        ddr_rd_valid = 1'b1; ddr_rd_data = rpat;
        tick();
        chk("late_done0", DW'(req_done), 0);
        chk("late_busy0", DW'(busy), 0);
        tick();
        chk("late_done1", DW'(req_done), 0);
        chk("late_rdata", rd_data, 0);
        ddr_rd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the user DDR port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 27: DDR word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 256: DDR data width; byte-enable width = DATA_WIDTH/8.
REQ-004 SHALL have one clock and one reset, asynchronous and active-low:
- i_clk  in  1  DDR user clock (200 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the requester ports, with requester k occupying slice k of each bus:
- i_req_wr  in  NUM_REQ  write request level per requester.
- i_req_rd  in  NUM_REQ  read request level per requester.
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  address per requester.
- i_req_wr_data  in  NUM_REQ*DATA_WIDTH  write data per requester.
- i_req_be_n  in  NUM_REQ*DATA_WIDTH/8  active-low byte enables per requester.
- o_req_done  out  NUM_REQ  one-cycle completion pulse per requester.
- o_rd_data  out  DATA_WIDTH  read data, valid only during an o_req_done pulse that completes a read.
REQ-006 SHALL have the DDR user-port ports:
- o_ddr_wr_data_valid  out  1  write command.
- o_ddr_wr_data  out  DATA_WIDTH  write data.
- o_ddr_wr_data_be_n  out  DATA_WIDTH/8  byte enables.
- o_ddr_addr  out  ADDR_WIDTH  address.
- o_ddr_rd  out  1  read command.
- i_ddr_wr_ack  in  1  write accepted.
- i_ddr_rd_ack  in  1  read command accepted.
- i_ddr_rd_data  in  DATA_WIDTH  read data.
- i_ddr_rd_data_valid  in  1  read data valid.
REQ-007 SHALL have the status ports:
- o_busy  out  1  high in any state other than IDLE.
- o_grant_id  out  clog2(NUM_REQ)  index of the current owner.

Function
REQ-008 SHALL implement the FSM states IDLE, WR_WAIT, RD_WAIT, RD_DATA and DONE, and SHALL register all outputs.
REQ-009 In IDLE, SHALL select a requester by round-robin over (i_req_wr|i_req_rd), searching from pointer p upward with wrap. At the same edge it SHALL latch the owner's addr, data and be_n onto o_ddr_*, and SHALL set p = owner+1 mod NUM_REQ.
REQ-010 If the owner has i_req_wr high, the FSM SHALL go to WR_WAIT with o_ddr_wr_data_valid=1. Otherwise it SHALL go to RD_WAIT with o_ddr_rd=1. Write has priority over read within one requester.
REQ-011 In WR_WAIT, on i_ddr_wr_ack=1 the FSM SHALL clear o_ddr_wr_data_valid, pulse o_req_done[owner] for one cycle, and enter DONE.
REQ-012 In RD_WAIT, on i_ddr_rd_ack=1 the FSM SHALL clear o_ddr_rd and enter RD_DATA.
REQ-013 In RD_DATA, on i_ddr_rd_data_valid=1 the FSM SHALL register o_rd_data=i_ddr_rd_data, pulse o_req_done[owner], and enter DONE.
REQ-014 DONE SHALL last exactly one cycle with no arbitration, then go to IDLE. A requester that drops its request on the edge where it samples o_req_done is never re-granted for the completed transfer.
REQ-015 Minimum grant-to-grant spacing SHALL be: write = 1 (grant) + ack wait + DONE + IDLE; back-to-back writes with immediate ack = one grant every 4 cycles.
REQ-016 SHALL ignore i_ddr_wr_ack outside WR_WAIT, i_ddr_rd_ack outside RD_WAIT, and i_ddr_rd_data_valid outside RD_DATA.
REQ-017 SHALL keep o_ddr_addr, o_ddr_wr_data and o_ddr_wr_data_be_n stable from grant until the command is acknowledged, independent of later requester input changes.
REQ-018 A request withdrawn after grant SHALL NOT abort the transfer; the transfer completes and o_req_done pulses.
REQ-019 At most one transfer SHALL be outstanding; no timeout is applied (ack/data waits are unbounded).
REQ-020 If no request is present in IDLE, the FSM SHALL stay in IDLE with p unchanged.
REQ-021 o_grant_id SHALL update at grant and hold until the next grant.

Reset
REQ-022 When i_rst_n=0, the block SHALL immediately force: state IDLE, p=0, all outputs 0 (o_ddr_wr_data_valid, o_ddr_rd, o_req_done, o_busy, o_grant_id, o_ddr_addr, o_ddr_wr_data, o_ddr_wr_data_be_n, o_rd_data).
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no o_req_done pulse; late DDR acks or data after release SHALL be ignored per REQ-016.
REQ-024 First arbitration after reset release SHALL occur on the first rising edge with i_rst_n=1 and favour requester 0.

Verification
REQ-025 Single write: i_req_wr[2]=1, addr=0x000_1234, be_n=0, ack after 3 cycles -> o_ddr_addr=0x0001234 and wr_data_valid held 3 cycles, then o_req_done=4'b0100 for 1 cycle.
REQ-026 Read: i_req_rd[1]=1, rd_ack after 2 cycles, rd_data_valid with data 0xA5..A5 after 5 more cycles -> o_req_done=4'b0010 with o_rd_data=0xA5..A5 in the same cycle.
REQ-027 Fairness: all four requesters write continuously, ack immediate -> grant order 0,1,2,3,0,1 with one grant every 4 cycles.
REQ-028 Same requester wr+rd: i_req_wr[3]=i_req_rd[3]=1 -> write serviced first, then read on the next grant to requester 3 once it is the only requester.
REQ-029 Reset mid-read: drive i_rst_n=0 in RD_DATA, then release and drive i_ddr_rd_data_valid=1 -> no o_req_done, o_busy=0, state IDLE.
REQ-030 Spurious acks: i_ddr_wr_ack=1 in IDLE and i_ddr_rd_data_valid=1 in WR_WAIT -> no state change, no done pulse.
